cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning CPU program-counter width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning width of one watch channel.
REQ-003 SHALL have parameter NCH, default 4, meaning number of watch channels (1..16).
REQ-004 SHALL have parameter CYC_W, default 16, meaning cycle-counter width.
REQ-005 SHALL have parameter HOLD_CYC, default 1, meaning cycles cpu_start is held low before a run (1..255).
REQ-006 SHALL have parameter TIMEOUT, default 300, meaning maximum RUN cycles before abort (1..2^CYC_W-1).
REQ-007 SHALL have parameter STABLE_N, default 4, meaning consecutive unchanged-PC cycles that declare a halt (2..255).
REQ-008 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-010 SHALL have port go  input  1  run request, sampled per cycle.
REQ-011 SHALL have port pc_i  input  PC_W  CPU program counter.
REQ-012 SHALL have port halt_i  input  1  CPU explicit halt indication (e.g. ecall retire).
REQ-013 SHALL have port watch_i  input  NCH*DATA_W  live CPU register values, channel k at bits [k*DATA_W +: DATA_W].
REQ-014 SHALL have port cpu_start  output  1  CPU start/enable; low holds CPU in its reset state.
REQ-015 SHALL have ports busy, done, timeout  output  1 each  run status.
REQ-016 SHALL have ports cycles  output  CYC_W  RUN cycle count; watch_o  output  NCH*DATA_W  snapshot, same channel packing as watch_i.

Function
REQ-017 SHALL implement FSM states IDLE, HOLD, RUN, DONE.
REQ-018 IDLE: go=1 -> HOLD next cycle; clear cycles, done, timeout, stable counter; watch_o retained.
REQ-019 HOLD: cpu_start=0 for exactly HOLD_CYC cycles, then -> RUN.
REQ-020 RUN: cpu_start=1; cycles increments by 1 each RUN cycle, saturating at all-ones.
REQ-021 RUN: stable counter resets to 0 when pc_i differs from previous-cycle pc_i, else increments; the first RUN cycle always counts as changed.
REQ-022 RUN exit on halt_i=1, or stable counter reaching STABLE_N-1, or cycles reaching TIMEOUT-1; -> DONE next cycle.
REQ-023 On RUN exit, the cycle's watch_i SHALL be captured into watch_o for all NCH channels in the same edge.
REQ-024 Halt (halt_i or PC-stable) and timeout in the same cycle: halt wins, timeout=0.
REQ-025 DONE: done=1, cpu_start=0, busy=0, cycles and watch_o frozen; go=1 -> HOLD (new run), else stay.
REQ-026 busy=1 exactly in HOLD and RUN; go while busy SHALL be ignored.
REQ-027 timeout=1 only in DONE after a timeout exit; done=1 in DONE regardless of exit cause.
REQ-028 All outputs SHALL be registered; go-to-HOLD latency 1 cycle; HOLD-to-RUN latency HOLD_CYC cycles.

Reset
REQ-029 rst=1 SHALL force IDLE, cpu_start=0, busy=0, done=0, timeout=0, cycles=0, watch_o=0, stable counter=0, at next edge.
REQ-030 rst SHALL take priority over go, halt_i and every FSM transition, including mid-RUN; no snapshot on reset.

Structure
REQ-031 FSM state encodings and the default timing constants SHALL live in shared package riscv_tb_pkg.
REQ-032 PC-stability detection SHALL be one sub-module, pc_stable_det (inputs clk, rst, clr, pc_i; output stable after STABLE_N).
REQ-033 Target size 120-400 RTL lines; no combinational path from any input to any output.

Verification
REQ-034 rst 2 cycles, go pulse, HOLD_CYC=1: cpu_start rises 2 cycles after go; busy=1 from cycle after go.
REQ-035 pc_i increments by 4 each cycle, halt_i=1 on RUN cycle 10 with watch_i ch2=0x0000_00AB -> done=1, timeout=0, cycles=10, watch_o ch2=0xAB.
REQ-036 pc_i frozen at 0x0000_0040 from RUN cycle 5, STABLE_N=4 -> done at cycle 8, cycles=8, timeout=0.
REQ-037 pc_i always changing, TIMEOUT=20 -> done=1, timeout=1, cycles=20; halt_i=1 at cycle 20 instead -> timeout=0.
REQ-038 rst=1 at RUN cycle 6 -> IDLE, all outputs 0 next cycle; go during RUN earlier ignored (cycles continuous).
REQ-039 go in DONE -> new run: done=0, cycles=0 at HOLD entry; watch_o keeps prior snapshot until next exit.

Source files
------------

// File: rtl/riscv_tb_pkg.sv
// Shared run-controller types: FSM state encoding and default timing constants.
package riscv_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_e;

  localparam int DEF_HOLD_CYC = 1;
  localparam int DEF_TIMEOUT  = 300;
  localparam int DEF_STABLE_N = 4;

endpackage

// File: rtl/pc_stable_det.sv
// Counts consecutive RUN cycles with an unchanged PC; stable flags the cycle the run length reaches STABLE_N.
module pc_stable_det #(
  parameter int PC_W     = 32,
  parameter int STABLE_N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [PC_W-1:0] pc_i,
  output logic            stable
);

  logic [PC_W-1:0] prev_pc;
  logic            primed;
  logic [7:0]      cnt;
  logic [7:0]      cnt_now;

  // The first cycle after clr has no valid previous PC, so it always counts as a change.
  always_comb begin
    cnt_now = 8'd0;
    if (primed && (pc_i == prev_pc)) begin
      cnt_now = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    end
  end

  assign stable = !clr && (cnt_now >= 8'(STABLE_N - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prev_pc <= '0;
      primed  <= 1'b0;
      cnt     <= 8'd0;
    end else begin
      prev_pc <= pc_i;
      primed  <= 1'b1;
      cnt     <= cnt_now;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Sequences one CPU run: hold the core in reset, release it, stop on halt / stable PC / timeout, snapshot registers.
module cpu_run_ctrl
  import riscv_tb_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int DATA_W   = 32,
  parameter int NCH      = 4,
  parameter int CYC_W    = 16,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int STABLE_N = DEF_STABLE_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [PC_W-1:0]       pc_i,
  input  logic                  halt_i,
  input  logic [NCH*DATA_W-1:0] watch_i,
  output logic                  cpu_start,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CYC_W-1:0]      cycles,
  output logic [NCH*DATA_W-1:0] watch_o,
  output run_state_e            state
);

  logic [7:0] hold_cnt;
  logic       stable;
  logic       stable_clr;
  logic       halt_hit;
  logic       timeout_hit;

  assign stable_clr  = (state != RUN);
  assign halt_hit    = halt_i || stable;
  assign timeout_hit = (cycles == CYC_W'(TIMEOUT - 1));

  pc_stable_det #(
    .PC_W     (PC_W),
    .STABLE_N (STABLE_N)
  ) u_stable (
    .clk    (clk),
    .rst    (rst),
    .clr    (stable_clr),
    .pc_i   (pc_i),
    .stable (stable)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cpu_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycles    <= '0;
      watch_o   <= '0;
      hold_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // watch_o is deliberately left alone so the last snapshot stays readable.
          if (go) begin
            state     <= HOLD;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cpu_start <= 1'b0;
            cycles    <= '0;
            hold_cnt  <= 8'd0;
          end
        end
        HOLD: begin
          if (hold_cnt == 8'(HOLD_CYC - 1)) begin
            state     <= RUN;
            cpu_start <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        RUN: begin
          if (cycles != {CYC_W{1'b1}}) begin
            cycles <= cycles + CYC_W'(1);
          end
          // A halt in the same cycle as the timeout limit is reported as a clean halt.
          if (halt_hit || timeout_hit) begin
            state     <= DONE;
            cpu_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            timeout   <= !halt_hit;
            watch_o   <= watch_i;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized and directed runs of cpu_run_ctrl checked by an exit-event scoreboard.
module tb_cpu_run_ctrl;
  import riscv_tb_pkg::*;

  localparam int PC_W     = 32;
  localparam int DATA_W   = 32;
  localparam int NCH      = 4;
  localparam int CYC_W    = 16;
  localparam int HOLD_CYC = 1;
  localparam int TIMEOUT  = 20;
  localparam int STABLE_N = 4;
  localparam int WW       = NCH * DATA_W;
  localparam int EXP_W    = 1 + CYC_W + WW;

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic [PC_W-1:0]   pc_i;
  logic              halt_i;
  logic [WW-1:0]     watch_i;
  logic              cpu_start;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CYC_W-1:0]  cycles;
  logic [WW-1:0]     watch_o;
  run_state_e        state;

  int checks   = 0;
  int failures = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [PC_W-1:0]  pc_a[1:TIMEOUT];
  logic             halt_a[1:TIMEOUT];
  logic             go_a[1:TIMEOUT];
  logic [WW-1:0]    watch_a[1:TIMEOUT];
  int               cur_exit;
  logic [WW-1:0]    last_watch;

  // clock/reset block
  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .PC_W     (PC_W),
    .DATA_W   (DATA_W),
    .NCH      (NCH),
    .CYC_W    (CYC_W),
    .HOLD_CYC (HOLD_CYC),
    .TIMEOUT  (TIMEOUT),
    .STABLE_N (STABLE_N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .pc_i      (pc_i),
    .halt_i    (halt_i),
    .watch_i   (watch_i),
    .cpu_start (cpu_start),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .cycles    (cycles),
    .watch_o   (watch_o),
    .state     (state)
  );

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_start"},   WW'(cpu_start), WW'(0));
    check({tag, "_busy"},    WW'(busy),      WW'(0));
    check({tag, "_done"},    WW'(done),      WW'(0));
    check({tag, "_timeout"}, WW'(timeout),   WW'(0));
    check({tag, "_cycles"},  WW'(cycles),    WW'(0));
    check({tag, "_watch"},   watch_o,        WW'(0));
    check({tag, "_state"},   WW'(state),     WW'(IDLE));
  endtask

  // Reference model: an exit happens on the first RUN cycle with halt, or whose
  // PC equals the PCs of the previous STABLE_N-1 RUN cycles, or at cycle TIMEOUT.
  function automatic bit window_hit(input int k);
    if (k < STABLE_N) return 1'b0;
    for (int j = 1; j < STABLE_N; j++) begin
      if (pc_a[k-j] != pc_a[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic predict();
    logic to_f;
    cur_exit = TIMEOUT;
    to_f     = 1'b1;
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (halt_a[k] || window_hit(k)) begin
        cur_exit = k;
        to_f     = 1'b0;
        break;
      end
    end
    exp_q.push_back({to_f, CYC_W'(cur_exit), watch_a[cur_exit]});
  endtask

  task automatic gen_linear();
    for (int k = 1; k <= TIMEOUT; k++) begin
      pc_a[k]    = PC_W'(32'h100 + 4 * k);
      halt_a[k]  = 1'b0;
      go_a[k]    = 1'b0;
      watch_a[k] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic gen_random();
    logic [PC_W-1:0] p;
    int halt_k;
    int freeze_k;
    p        = $urandom & 32'hFFFF_FFFC;
    halt_k   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 5));
    freeze_k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TIMEOUT)) : 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (!(k > 1 && ((freeze_k != 0 && k > freeze_k) || $urandom_range(0, 3) == 0))) begin
        p = p + 4;
      end
      pc_a[k]    = p;
      halt_a[k]  = (k == halt_k);
      go_a[k]    = ($urandom_range(0, 5) == 0);
      watch_a[k] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // driver: go pulse, HOLD checks, then per-RUN-cycle inputs; optional reset at RUN cycle rst_at
  task automatic drive_run(input int rst_at, input bit two_go);
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = two_go;
    check("hold_busy",    WW'(busy),      WW'(1));
    check("hold_start",   WW'(cpu_start), WW'(0));
    check("hold_done",    WW'(done),      WW'(0));
    check("hold_timeout", WW'(timeout),   WW'(0));
    check("hold_cycles",  WW'(cycles),    WW'(0));
    check("hold_watch",   watch_o,        last_watch);
    for (int h = 1; h < HOLD_CYC; h++) begin
      @(negedge clk);
      go = 1'b0;
      check("hold_start_low", WW'(cpu_start), WW'(0));
    end
    @(negedge clk);
    go = 1'b0;
    check("run_start", WW'(cpu_start), WW'(1));
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (k > 1) @(negedge clk);
      pc_i    = pc_a[k];
      halt_i  = halt_a[k];
      watch_i = watch_a[k];
      go      = go_a[k] && (k <= cur_exit);
      if (k <= cur_exit) check("run_cycles", WW'(cycles), WW'(k - 1));
      if (k == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_cleared("midrun_rst");
        rst        = 1'b0;
        go         = 1'b0;
        halt_i     = 1'b0;
        last_watch = '0;
        return;
      end
    end
    @(negedge clk);
    go         = 1'b0;
    halt_i     = 1'b0;
    last_watch = watch_a[cur_exit];
  endtask

  // scoreboard monitor: compares on every rising edge of done
  initial begin
    logic             done_q;
    logic [EXP_W-1:0] e;
    done_q = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done && !done_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 cycles=%0d expected no exit", cycles);
        end else begin
          e = exp_q.pop_front();
          check("exit_timeout", WW'(timeout),   WW'(e[EXP_W-1]));
          check("exit_cycles",  WW'(cycles),    WW'(e[WW +: CYC_W]));
          check("exit_watch",   watch_o,        e[WW-1:0]);
          check("exit_busy",    WW'(busy),      WW'(0));
          check("exit_start",   WW'(cpu_start), WW'(0));
        end
      end
      done_q = done;
    end
  end

  initial begin
    rst        = 1'b1;
    go         = 1'b0;
    halt_i     = 1'b0;
    pc_i       = '0;
    watch_i    = {$urandom, $urandom, $urandom, $urandom};
    last_watch = '0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;

    // halt on RUN cycle 10 with channel 2 = 0xAB, go ignored mid-run
    gen_linear();
    halt_a[10] = 1'b1;
    watch_a[10][2*DATA_W +: DATA_W] = 32'h0000_00AB;
    go_a[3] = 1'b1;
    predict();
    drive_run(0, 1'b0);
    check("ch2_snapshot", WW'(watch_o[2*DATA_W +: DATA_W]), WW'(32'hAB));

    // PC frozen at 0x40 from RUN cycle 5
    gen_linear();
    for (int k = 1; k <= TIMEOUT; k++) pc_a[k] = (k >= 5) ? 32'h40 : PC_W'(32'h40 - 4 * (5 - k));
    predict();
    drive_run(0, 1'b1);

    // always-changing PC: timeout; then halt on the timeout cycle
    gen_linear();
    predict();
    drive_run(0, 1'b0);
    gen_linear();
    halt_a[TIMEOUT] = 1'b1;
    predict();
    drive_run(0, 1'b0);

    // reset at RUN cycle 6 after an ignored go; no snapshot expected
    gen_linear();
    go_a[3]  = 1'b1;
    cur_exit = TIMEOUT;
    drive_run(6, 1'b0);

    for (int r = 0; r < 25; r++) begin
      gen_random();
      predict();
      drive_run(0, bit'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", WW'(exp_q.size()), WW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
